// File: rtl/fir_stream_conv_pkg.sv
// Shared types and helpers for the streaming FIR convolver.
package fir_stream_conv_pkg;

    // Control states of the time-shared MAC sequencer.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_MAC   = 3'd2,
        ST_OUT   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // Accumulator width that can hold the sum of taps full-precision products without overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Width of the rounding/saturation working value: one guard bit above the accumulator.
    function automatic int round_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fir_stream_conv_if.sv
// Sample-in / result-out stream bundle of the FIR convolver.
// The slave modport is the convolver's view; master is the source/sink side.
interface fir_stream_conv_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [OUT_W-1:0]  m_data;
    logic                     m_last;
    logic                     m_sat;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_sat
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_sat
    );
endinterface

// File: rtl/fir_stream_conv_round_sat.sv
// Round-half-up, arithmetic shift and saturate an accumulator to the output width.
module fir_stream_conv_round_sat
    import fir_stream_conv_pkg::*;
#(
    parameter int ACC_W     = 34,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 15
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    sat
);
    localparam int EW = round_width(ACC_W);
    localparam logic signed [EW-1:0] RND_C = {{(EW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [EW-1:0] MAX_C = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_C = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EW-1:0] rounded_s;
    logic signed [EW-1:0] shifted_s;

    // Add half an LSB, drop fraction bits, clip into the signed output range.
    always_comb begin
        rounded_s = $signed({acc[ACC_W-1], acc}) + RND_C;
        shifted_s = rounded_s >>> FRAC_BITS;
        if (shifted_s > MAX_C) begin
            data_out = MAX_C[OUT_W-1:0];
            sat      = 1'b1;
        end else if (shifted_s < MIN_C) begin
            data_out = MIN_C[OUT_W-1:0];
            sat      = 1'b1;
        end else begin
            data_out = shifted_s[OUT_W-1:0];
            sat      = 1'b0;
        end
    end
endmodule

// File: rtl/fir_stream_conv.sv
// Streaming full linear convolution y[n] = sum_k h[k]*x[n-k] with one time-shared MAC,
// runtime-loadable coefficients and an automatic zero-flush tail of TAPS-1 outputs.
module fir_stream_conv
    import fir_stream_conv_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int COEF_W    = 16,
    parameter  int TAPS      = 20,
    parameter  int OUT_W     = 16,
    parameter  int FRAC_BITS = 15,
    localparam int ACC_W     = acc_width(DATA_W, COEF_W, TAPS),
    localparam int AW        = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_err,
    fir_stream_conv_if.slave         bus,
    output logic                     busy,
    output logic                     done
);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_C   = (AW + 1)'(TAPS);

    logic signed [COEF_W-1:0] coef_r  [TAPS];
    logic signed [DATA_W-1:0] dline_r [TAPS];
    logic [AW-1:0]            tap_cnt_r;
    logic [AW-1:0]            flush_cnt_r;
    logic signed [ACC_W-1:0]  acc_r;
    state_t                   state_r;
    logic                     last_seen_r;
    logic                     s_ready_r;
    logic                     m_valid_r;
    logic signed [OUT_W-1:0]  m_data_r;
    logic                     m_last_r;
    logic                     m_sat_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     coef_err_r;

    logic                     coef_ok_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [OUT_W-1:0]  rs_data_s;
    logic                     rs_sat_s;

    // Writes are only legal while idle and for an existing tap.
    always_comb begin
        coef_ok_s = (state_r == ST_IDLE) && ({1'b0, coef_addr} < TAPS_C);
    end

    // Full-precision product of the tap currently addressed by the MAC counter.
    always_comb begin
        prod_s = coef_r[tap_cnt_r] * dline_r[tap_cnt_r];
    end

    fir_stream_conv_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc      (acc_r),
        .data_out (rs_data_s),
        .sat      (rs_sat_s)
    );

    // Coefficient register file and the one-cycle reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= {COEF_W{1'b0}};
            end
            coef_err_r <= 1'b0;
        end else begin
            coef_err_r <= coef_we & ~coef_ok_s;
            if (coef_we && coef_ok_s) begin
                coef_r[coef_addr] <= coef_data;
            end
        end
    end

    // Sequencer: accept/shift, TAPS-cycle MAC, output hold, zero-flush tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                dline_r[i] <= {DATA_W{1'b0}};
            end
            tap_cnt_r   <= {AW{1'b0}};
            flush_cnt_r <= {AW{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            last_seen_r <= 1'b0;
            s_ready_r   <= 1'b1;
            m_valid_r   <= 1'b0;
            m_data_r    <= {OUT_W{1'b0}};
            m_last_r    <= 1'b0;
            m_sat_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_WAIT: begin
                    if (bus.s_valid) begin
                        // A new frame starts from an all-zero history.
                        for (int i = TAPS - 1; i > 0; i--) begin
                            dline_r[i] <= (state_r == ST_IDLE) ? {DATA_W{1'b0}} : dline_r[i-1];
                        end
                        dline_r[0] <= bus.s_data;
                        if (state_r == ST_IDLE) begin
                            flush_cnt_r <= {AW{1'b0}};
                        end
                        last_seen_r <= bus.s_last;
                        acc_r       <= {ACC_W{1'b0}};
                        tap_cnt_r   <= {AW{1'b0}};
                        state_r     <= ST_MAC;
                        s_ready_r   <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_MAC: begin
                    acc_r     <= acc_r + ACC_W'(prod_s);
                    tap_cnt_r <= tap_cnt_r + AW'(1'b1);
                    if (tap_cnt_r == LAST_TAP) begin
                        state_r <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (!m_valid_r) begin
                        m_data_r  <= rs_data_s;
                        m_sat_r   <= rs_sat_s;
                        m_last_r  <= last_seen_r && (flush_cnt_r == LAST_TAP);
                        m_valid_r <= 1'b1;
                    end else if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        if (m_last_r) begin
                            m_last_r  <= 1'b0;
                            state_r   <= ST_IDLE;
                            s_ready_r <= 1'b1;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else if (last_seen_r) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r   <= ST_WAIT;
                            s_ready_r <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        dline_r[i] <= dline_r[i-1];
                    end
                    dline_r[0]  <= {DATA_W{1'b0}};
                    flush_cnt_r <= flush_cnt_r + AW'(1'b1);
                    acc_r       <= {ACC_W{1'b0}};
                    tap_cnt_r   <= {AW{1'b0}};
                    state_r     <= ST_MAC;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    s_ready_r <= 1'b1;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_last  = m_last_r;
    assign bus.m_sat   = m_sat_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign coef_err    = coef_err_r;
endmodule

// File: tb/tb_fir_stream_conv.sv
// Scoreboard bench for fir_stream_conv (TAPS=4), plus a TAPS=5 instance for the
// out-of-range coefficient address case.
module tb_fir_stream_conv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [15:0] coef_data;
    logic              coef_err, busy, done;

    logic              coef_we5;
    logic [2:0]        coef_addr5;
    logic signed [15:0] coef_data5;
    logic              coef_err5, busy5, done5;

    fir_stream_conv_if #(.DATA_W(16), .OUT_W(16)) bus ();
    fir_stream_conv_if #(.DATA_W(16), .OUT_W(16)) bus5 ();

    fir_stream_conv #(.DATA_W(16), .COEF_W(16), .TAPS(4), .OUT_W(16), .FRAC_BITS(15)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(coef_err), .bus(bus), .busy(busy), .done(done)
    );

    fir_stream_conv #(.DATA_W(16), .COEF_W(16), .TAPS(5), .OUT_W(16), .FRAC_BITS(15)) dut5 (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we5), .coef_addr(coef_addr5),
        .coef_data(coef_data5), .coef_err(coef_err5), .bus(bus5), .busy(busy5), .done(done5)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   out_idx  = 0;

    // Monitor: compare every output handshake against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.m_valid && bus.m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output #%0d: got data=%h last=%b sat=%b, none expected",
                         out_idx, bus.m_data, bus.m_last, bus.m_sat);
            end else begin
                e = exp_q.pop_front();
                if ({bus.m_data, bus.m_last, bus.m_sat} !== {e.data, e.last, e.sat}) begin
                    n_fail++;
                    $display("FAIL output #%0d: got data=%h last=%b sat=%b, expected data=%h last=%b sat=%b",
                             out_idx, bus.m_data, bus.m_last, bus.m_sat, e.data, e.last, e.sat);
                end
            end
            out_idx++;
        end
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l, input logic s);
        exp_t e;
        e.data = d; e.last = l; e.sat = s;
        exp_q.push_back(e);
    endtask

    task automatic load4(input logic [15:0] h0, input logic [15:0] h1,
                         input logic [15:0] h2, input logic [15:0] h3);
        logic [15:0] h [4];
        h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
        for (int k = 0; k < 4; k++) begin
            coef_we = 1'b1; coef_addr = 2'(k); coef_data = h[k];
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        bit ok = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.s_ready) begin ok = 1'b1; break; end
        end
        tick();
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: sample %h not accepted", d);
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 600; c++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    // Behavioural reference: direct convolution with round-half-up and clipping.
    task automatic model_push(input logic signed [15:0] h [4], input logic signed [15:0] x [$]);
        int L = x.size();
        for (int n = 0; n < L + 3; n++) begin
            longint acc = 0;
            longint r;
            for (int k = 0; k < 4; k++) begin
                if (n - k >= 0 && n - k < L) acc += longint'(h[k]) * longint'(x[n-k]);
            end
            r = (acc + 64'sd16384) >>> 15;
            if (r > 64'sd32767)       push(16'h7FFF, n == L + 2, 1'b1);
            else if (r < -64'sd32768) push(16'h8000, n == L + 2, 1'b1);
            else                      push(16'(r), n == L + 2, 1'b0);
        end
    endtask

    initial begin
        logic signed [15:0] hr [4];
        logic signed [15:0] xr [$];
        int base;

        coef_we = 1'b0; coef_addr = 2'd0; coef_data = 16'sd0;
        coef_we5 = 1'b0; coef_addr5 = 3'd0; coef_data5 = 16'sd0;
        bus.s_valid = 1'b0; bus.s_data = 16'sd0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        bus5.s_valid = 1'b0; bus5.s_data = 16'sd0; bus5.s_last = 1'b0; bus5.m_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data",  32'(bus.m_data),  32'd0);
        check("rst_m_last",  32'(bus.m_last),  32'd0);
        check("rst_m_sat",   32'(bus.m_sat),   32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_coef_err", 32'(coef_err),   32'd0);

        // Impulse
        load4(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        done_cnt = 0;
        push(16'h2000, 1'b0, 1'b0); push(16'h1000, 1'b0, 1'b0);
        push(16'h0800, 1'b0, 1'b0); push(16'h0400, 1'b1, 1'b0);
        send(16'h4000, 1'b1);
        check("impulse_busy", 32'(busy), 32'd1);
        drain("impulse_drain");
        check("impulse_done", 32'(done_cnt), 32'd1);
        check("impulse_idle_busy", 32'(busy), 32'd0);
        check("impulse_idle_s_ready", 32'(bus.s_ready), 32'd1);

        // Step, with a rejected coefficient write mid-frame
        done_cnt = 0;
        push(16'h2000, 1'b0, 1'b0); push(16'h3000, 1'b0, 1'b0); push(16'h3800, 1'b0, 1'b0);
        push(16'h1C00, 1'b0, 1'b0); push(16'h0C00, 1'b0, 1'b0); push(16'h0400, 1'b1, 1'b0);
        send(16'h4000, 1'b0);
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h7FFF;
        tick();
        coef_we = 1'b0;
        check("busy_write_coef_err", 32'(coef_err), 32'd1);
        tick();
        check("coef_err_pulse_end", 32'(coef_err), 32'd0);
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b1);
        drain("step_drain");
        check("step_done", 32'(done_cnt), 32'd1);

        // Step again with backpressure on y[1]
        done_cnt = 0;
        base = out_idx;
        push(16'h2000, 1'b0, 1'b0); push(16'h3000, 1'b0, 1'b0); push(16'h3800, 1'b0, 1'b0);
        push(16'h1C00, 1'b0, 1'b0); push(16'h0C00, 1'b0, 1'b0); push(16'h0400, 1'b1, 1'b0);
        fork
            begin
                send(16'h4000, 1'b0);
                send(16'h4000, 1'b0);
                send(16'h4000, 1'b1);
            end
            begin
                bit seen = 1'b0;
                for (int c = 0; c < 300; c++) begin
                    if (out_idx == base + 1) break;
                    tick();
                end
                bus.m_ready = 1'b0;
                for (int c = 0; c < 300; c++) begin
                    if (bus.m_valid) begin seen = 1'b1; break; end
                    tick();
                end
                check("bp_y1_valid_seen", 32'(seen), 32'd1);
                for (int c = 0; c < 10; c++) begin
                    tick();
                    check("bp_hold_m_data",  32'(bus.m_data),  32'h0000_3000);
                    check("bp_hold_m_valid", 32'(bus.m_valid), 32'd1);
                    check("bp_s_ready_low",  32'(bus.s_ready), 32'd0);
                end
                bus.m_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_done", 32'(done_cnt), 32'd1);

        // Positive saturation
        load4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        push(16'h7FFE, 1'b0, 1'b0); push(16'h7FFF, 1'b0, 1'b1); push(16'h7FFF, 1'b0, 1'b1);
        push(16'h7FFF, 1'b0, 1'b1); push(16'h7FFF, 1'b0, 1'b1); push(16'h7FFF, 1'b0, 1'b1);
        push(16'h7FFE, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h7FFF, i == 3);
        drain("sat_pos_drain");

        // Negative saturation
        push(16'h8001, 1'b0, 1'b0); push(16'h8000, 1'b0, 1'b1); push(16'h8000, 1'b0, 1'b1);
        push(16'h8000, 1'b0, 1'b1); push(16'h8000, 1'b0, 1'b1); push(16'h8000, 1'b0, 1'b1);
        push(16'h8001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h8000, i == 3);
        drain("sat_neg_drain");

        // Out-of-range coefficient address on the TAPS=5 instance
        coef_we5 = 1'b1; coef_addr5 = 3'd5; coef_data5 = 16'h1234;
        tick();
        coef_we5 = 1'b0;
        check("addr5_coef_err", 32'(coef_err5), 32'd1);
        coef_we5 = 1'b1; coef_addr5 = 3'd4;
        tick();
        coef_we5 = 1'b0;
        check("addr4_coef_ok", 32'(coef_err5), 32'd0);

        // Reset mid-MAC
        load4(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send(16'h4000, 1'b1);
        tick();
        rst_n = 1'b0;
        #2;
        check("midrst_s_ready", 32'(bus.s_ready), 32'd1);
        check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        check("midrst_m_data",  32'(bus.m_data),  32'd0);
        check("midrst_m_sat",   32'(bus.m_sat),   32'd0);
        check("midrst_busy",    32'(busy),        32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        // Coefficients were cleared: an impulse now yields zeros.
        push(16'h0000, 1'b0, 1'b0); push(16'h0000, 1'b0, 1'b0);
        push(16'h0000, 1'b0, 1'b0); push(16'h0000, 1'b1, 1'b0);
        send(16'h4000, 1'b1);
        drain("after_rst_zero_drain");
        done_cnt = 0;
        load4(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        push(16'h2000, 1'b0, 1'b0); push(16'h1000, 1'b0, 1'b0);
        push(16'h0800, 1'b0, 1'b0); push(16'h0400, 1'b1, 1'b0);
        send(16'h4000, 1'b1);
        drain("after_rst_impulse_drain");
        check("after_rst_done", 32'(done_cnt), 32'd1);

        // Random frame against the reference convolution
        for (int k = 0; k < 4; k++) hr[k] = 16'($urandom);
        load4(hr[0], hr[1], hr[2], hr[3]);
        for (int i = 0; i < 7; i++) xr.push_back(16'($urandom));
        model_push(hr, xr);
        for (int i = 0; i < 7; i++) send(xr[i], i == 6);
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
